// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment encodings are active-low in {g,f,e,d,c,b,a} order.
package seg_pkg;

    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // Hex digit to active-low segment pattern, indexed by nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // One complete display configuration as written by the host
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
    } disp_cfg_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with blank phase,
// leading-zero blanking and frame-synchronous double-buffered host writes.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_en,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       digit_q, digit_d;
    state_e           state_q, state_d;
    disp_cfg_t        pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    disp_cfg_t        disp_q, disp_d;
    logic             wr_ready_q, wr_ready_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_start_q, frame_start_d;

    logic             slot_wrap_c;
    logic             boundary_c;
    logic [3:0]       cur_nibble_c;
    logic [6:0]       dec_seg_c;
    logic [3:0]       lz_vec_c;
    logic             show_c;

    assign slot_wrap_c  = (slot_cnt_q == SLOT_LAST);
    assign boundary_c   = slot_wrap_c && (digit_q == 2'd3);
    assign cur_nibble_c = disp_q.data[{digit_q, 2'b00} +: 4];

    // Digit k is blanked when it and every digit to its left are zero
    assign lz_vec_c[0] = 1'b0;
    assign lz_vec_c[1] = disp_q.lz && (disp_q.data[15:4]  == 12'h000);
    assign lz_vec_c[2] = disp_q.lz && (disp_q.data[15:8]  == 8'h00);
    assign lz_vec_c[3] = disp_q.lz && (disp_q.data[15:12] == 4'h0);

    assign show_c = disp_q.en[digit_q] && !lz_vec_c[digit_q];

    hex_to_7seg u_dec (
        .nibble (cur_nibble_c),
        .seg_c  (dec_seg_c)
    );

    always_comb begin
        slot_cnt_d    = slot_cnt_q;
        digit_d       = digit_q;
        state_d       = state_q;
        pend_d        = pend_q;
        pend_full_d   = pend_full_q;
        disp_d        = disp_q;
        wr_ready_d    = wr_ready_q;
        an_d          = ANODE_OFF;
        seg_d         = SEG_OFF;
        dp_d          = 1'b1;
        frame_start_d = 1'b0;

        // Slot timer and digit sequencing
        if (slot_wrap_c) begin
            slot_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end

        case (state_q)
            BLANK: if (slot_cnt_q == BLANK_LAST) state_d = DRIVE;
            DRIVE: if (slot_wrap_c)              state_d = BLANK;
        endcase

        // Commit at frame boundary has priority; ready is low whenever pending is full
        if (boundary_c && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else if (wr_valid && wr_ready_q) begin
            pend_d      = '{data: wr_data, dp: wr_dp, en: wr_en, lz: lz_blank};
            pend_full_d = 1'b1;
        end
        wr_ready_d = !pend_full_d;

        if (state_q == DRIVE && show_c) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = dec_seg_c;
            dp_d  = ~disp_q.dp[digit_q];
        end

        frame_start_d = (slot_cnt_d == '0) && (digit_d == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            digit_q       <= 2'd0;
            state_q       <= BLANK;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            disp_q        <= '0;
            wr_ready_q    <= 1'b1;
            an_q          <= ANODE_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_q       <= digit_d;
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            disp_q        <= disp_d;
            wr_ready_q    <= wr_ready_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign digit_sel   = digit_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller: frame-position model plus
// directed literal checks of decode, blanking, handshake and reset.
module tb_seg_scan_controller;

    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [3:0]  wr_en;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_start;

    int n_checks = 0;
    int n_pass   = 0;

    seg_scan_controller #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_en       (wr_en),
        .lz_blank    (lz_blank),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] hex_lut(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic bit digit_shown(input logic [15:0] d, input logic [3:0] en,
                                       input logic lz, input int dig);
        if (!en[dig]) return 1'b0;
        if (lz && dig > 0 && (d >> (4 * dig)) == 16'h0) return 1'b0;
        return 1'b1;
    endfunction

    // Model state: frame position and the host-visible buffers
    bit          model_valid = 1'b0;
    int          pos = 0;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_dp, p_dp, m_en, p_en;
    logic        m_lz, p_lz, p_full;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs, e_rdy;
    logic [1:0]  e_dsel;

    always @(posedge clk) begin
        int cnt;
        int dig;
        if (!rst_n) begin
            model_valid = 1'b1;
            pos = 0;
            m_data = '0; m_dp = '0; m_en = '0; m_lz = 1'b0;
            p_data = '0; p_dp = '0; p_en = '0; p_lz = 1'b0; p_full = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            e_dsel = 2'd0; e_fs = 1'b0; e_rdy = 1'b1;
        end else begin
            // What the pins show after this edge is what the cycle just ended asked for
            cnt = pos % CLK_DIV;
            dig = pos / CLK_DIV;
            if (cnt >= BLANK_CYCLES && digit_shown(m_data, m_en, m_lz, dig)) begin
                e_an  = ~(4'b0001 << dig);
                e_seg = hex_lut(4'((m_data >> (4 * dig)) & 16'hF));
                e_dp  = ~m_dp[dig];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            if (pos == FRAME - 1 && p_full) begin
                m_data = p_data; m_dp = p_dp; m_en = p_en; m_lz = p_lz;
                p_full = 1'b0;
            end else if (wr_valid && e_rdy) begin
                p_data = wr_data; p_dp = wr_dp; p_en = wr_en; p_lz = lz_blank;
                p_full = 1'b1;
            end
            e_rdy  = !p_full;
            pos    = (pos + 1) % FRAME;
            e_dsel = 2'(pos / CLK_DIV);
            e_fs   = (pos == 0);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("m_an",          32'(an),          32'(e_an));
            chk("m_seg",         32'(seg),         32'(e_seg));
            chk("m_dp",          32'(dp),          32'(e_dp));
            chk("m_digit_sel",   32'(digit_sel),   32'(e_dsel));
            chk("m_frame_start", 32'(frame_start), 32'(e_fs));
            chk("m_wr_ready",    32'(wr_ready),    32'(e_rdy));
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] d, input logic [3:0] dpv,
                            input logic [3:0] en, input logic lz);
        bit acc;
        wr_data = d; wr_dp = dpv; wr_en = en; lz_blank = lz;
        wr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = wr_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                wr_valid = 1'b0;
                return;
            end
        end
        wr_valid = 1'b0;
        n_checks++;
        $display("FAIL write_timeout: got no accept expected accept within 200 cycles");
    endtask

    task automatic wait_fs();
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL fs_timeout: got no frame_start expected one within 100 cycles");
        end
    endtask

    // From a frame_start negedge, check blank then first driven cycle of each slot
    task automatic check_frame(input string tag, input logic [3:0] ean[4],
                               input logic [6:0] eseg[4], input logic edp[4]);
        for (int s = 0; s < 4; s++) begin
            adv(s == 0 ? 2 : 7);
            chk({tag, "_blank_an"}, 32'(an), 32'h0000000F);
            adv(1);
            chk({tag, "_an"},  32'(an),  32'(ean[s]));
            chk({tag, "_seg"}, 32'(seg), 32'(eseg[s]));
            chk({tag, "_dp"},  32'(dp),  32'(edp[s]));
        end
    endtask

    logic [3:0] lan[4];
    logic [6:0] lseg[4];
    logic       ldp[4];
    time        t0;

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dp = '0; wr_en = '0; lz_blank = 1'b0;

        // Reset values while held in reset
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_digit_sel", 32'(digit_sel), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        chk("rst_frame_start", 32'(frame_start), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        adv(40);

        // Plain digits with dp on digit 0
        do_write(16'h1234, 4'b0001, 4'hF, 1'b0);
        wait_fs();
        lan  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        lseg = '{7'h19, 7'h30, 7'h24, 7'h79};
        ldp  = '{1'b0, 1'b1, 1'b1, 1'b1};
        check_frame("d1234", lan, lseg, ldp);

        // Frame period
        wait_fs();
        t0 = $time;
        wait_fs();
        chk("fs_period", 32'($time - t0), 32'(FRAME * 10));

        // Back-to-back writes A then B
        do_write(16'hAAAA, 4'h0, 4'hF, 1'b0);
        @(negedge clk);
        chk("ready_low_after_a", 32'(wr_ready), 32'h0);
        do_write(16'h5555, 4'h0, 4'hF, 1'b0);
        adv(3);
        chk("a_shown_an", 32'(an), 32'hE);
        chk("a_shown_seg", 32'(seg), 32'h08);
        wait_fs();
        adv(3);
        chk("b_shown_an", 32'(an), 32'hE);
        chk("b_shown_seg", 32'(seg), 32'h12);

        // Leading-zero blanking
        do_write(16'h0050, 4'h0, 4'hF, 1'b1);
        wait_fs();
        lan  = '{4'b1110, 4'b1101, 4'hF, 4'hF};
        lseg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        ldp  = '{1'b1, 1'b1, 1'b1, 1'b1};
        check_frame("lz0050", lan, lseg, ldp);
        do_write(16'h0000, 4'hF, 4'hF, 1'b1);
        wait_fs();
        lan  = '{4'b1110, 4'hF, 4'hF, 4'hF};
        lseg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        ldp  = '{1'b0, 1'b1, 1'b1, 1'b1};
        check_frame("lz0000", lan, lseg, ldp);

        // Reset during slot-2 drive
        do_write(16'h8888, 4'h0, 4'hF, 1'b0);
        wait_fs();
        adv(20);
        chk("pre_rst_an", 32'(an), 32'hB);
        chk("pre_rst_seg", 32'(seg), 32'h00);
        rst_n = 1'b0;
        adv(1);
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_digit_sel", 32'(digit_sel), 32'h0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'h1);
        rst_n = 1'b1;
        adv(2 * FRAME + 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
Scan controller for the 4-digit multiplexed seven-segment display. It owns digit-select sequencing: a per-digit slot timer, an anti-ghosting blank phase, and a hex-to-segment decode. Host writes are double-buffered and committed only at frame boundaries, so the display never tears. It sits between host/user logic and the board anode/cathode pins, and replaces a free-running 2-bit refresh count with a managed sequencer.

Parameters:
CLK_DIV, 100000, clk cycles per digit slot; legal range > BLANK_CYCLES.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range >= 1.

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_valid  in  1  host write request
wr_ready  out  1  high when pending buffer empty
wr_data  in  16  four hex nibbles; [3:0]=digit0 (rightmost)
wr_dp  in  4  decimal point per digit, 1=lit
wr_en  in  4  digit enable per digit, 1=shown
lz_blank  in  1  leading-zero blanking enable; sampled with the write
an  out  4  anodes, active-low, one-hot-low or all 1
seg  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}
dp  out  1  decimal-point cathode, active-low
digit_sel  out  2  current slot digit index
frame_start  out  1  one-cycle pulse at start of slot 0

Behaviour:
- Reset (rst_n=0 at an edge): an=4'hF, seg=7'h7F, dp=1, digit_sel=0, frame_start=0, wr_ready=1, slot_cnt=0, state=BLANK, pending buffer cleared, display regs (data=0, dp=0, en=0, lz=0) cleared. Reset mid-operation has the same effect on the next edge.
- slot_cnt counts 0..CLK_DIV-1 and wraps. On wrap, digit_sel increments mod 4 (3->0).
- FSM states: BLANK and DRIVE.
  - BLANK -> DRIVE when slot_cnt==BLANK_CYCLES-1.
  - DRIVE -> BLANK when slot_cnt==CLK_DIV-1.
- Outputs are registered with one cycle of latency from the state/counter decision.
- BLANK: an=4'hF, seg=7'h7F, dp=1.
- DRIVE: an[digit_sel]=0 only if en[digit_sel]=1 and the digit is not LZ-blanked. seg is the decode of the nibble; dp = ~dp_reg[digit_sel]. When the digit is suppressed: an=4'hF, seg=7'h7F, dp=1.
- Leading-zero blanking (lz=1): digit k (k=3..1) is blanked iff nibbles k..3 are all 0. Digit 0 is never LZ-blanked. A blanked digit also suppresses its dp.
- Hex decode (active-low, gfedcba): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Write handshake:
  - A write is accepted when wr_valid && wr_ready; {wr_data, wr_dp, wr_en, lz_blank} is latched into pending and wr_ready drops the next cycle.
  - Frame boundary = the cycle where digit_sel==3 and slot_cnt==CLK_DIV-1. At that edge, if pending is full: copy it to the display regs, clear pending, wr_ready=1 the next cycle.
  - A write accepted in the boundary cycle (pending was empty) is held in pending and commits at the following boundary.
  - wr_valid while wr_ready=0 is ignored; the host must hold it.
- frame_start is high for exactly one cycle: the first cycle with digit_sel==0 and slot_cnt==0. This coincides with the first cycle at which committed data is visible.
- Frame period = 4*CLK_DIV cycles.

Decomposition:
- Package seg_pkg holds:
  - hex-to-segment constant table
  - ANODE_OFF=4'hF and SEG_OFF=7'h7F
  - FSM state encoding (BLANK, DRIVE)
- One sub-module, hex_to_7seg: 4-bit nibble in, 7-bit active-low segments out, purely combinational.
- Counter, FSM, buffers and LZ logic stay in the top.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2):
1. Reset: rst_n=0 for 3 cycles -> an=F, seg=7F, dp=1, digit_sel=0, wr_ready=1, frame_start=0. No anode goes low until a write with en!=0 commits.
2. Write 16'h1234, en=F, dp=4'b0001, lz=0 -> after the next frame_start, each slot drives: slot0 an=1110 seg=19 dp=0; slot1 an=1101 seg=30; slot2 an=1011 seg=24; slot3 an=0111 seg=79; dp=1 in slots 1-3.
3. Blank timing: in every slot the first 2 cycles (+1 latency) show an=F. digit_sel sequence is 0,1,2,3,0. frame_start pulses every 32 cycles, exactly one cycle wide.
4. Back-to-back writes A=16'hAAAA then B=16'h5555 -> A accepted, wr_ready=0 until the boundary, A displayed in the next frame. B is accepted the cycle after wr_ready rises and is displayed one frame later. No frame shows mixed A/B nibbles.
5. LZ blanking: 16'h0050, en=F, lz=1 -> slots 3 and 2 an=F; slot1 seg=12; slot0 seg=40. With 16'h0000: only digit0 is lit, seg=40.
6. Reset mid-frame during the slot-2 DRIVE phase -> next cycle an=F, digit_sel=0, wr_ready=1. The display stays dark with no stale data after reset is released.
